vga_timing_ctl: RTL and testbench
=================================

// Module: vga_timing_ctl
// PURPOSE
// - Parametrised VGA timing generator and output stage; drives the top-level vs/hs/r/g/b pins.
// - Produces hcount/vcount/blank timing for the draw pipeline (background, ducks, crosshair).
// - Re-aligns sync with the pipeline's rgb result through a PIPE_DELAY-stage delay line.
// - Forces black outside the active area.
// PARAMETERS
// - H_ACTIVE  1024  visible pixels per line
// - H_FP      24    horizontal front porch, pixels
// - H_SYNC    136   hsync pulse width, pixels
// - H_BP      160   horizontal back porch, pixels (H_TOTAL = 1344)
// - V_ACTIVE  768   visible lines per frame
// - V_FP      3     vertical front porch, lines
// - V_SYNC    6     vsync pulse width, lines
// - V_BP      29    vertical back porch, lines (V_TOTAL = 806)
// - SYNC_POL  1'b0  active level of hs/vs (0 = negative, per 1024x768@60)
// - PIPE_DELAY 2    rgb_in latency in clk cycles relative to hcount/vcount; range 1..8
// - CW        11    hcount/vcount width; requires 2**CW >= max(H_TOTAL, V_TOTAL)
// PORTS
// - clk          in   1    pixel clock, 65 MHz
// - rst          in   1    synchronous reset, active-low
// - pattern_sel  in   2    test pattern select; ignored unless VGA_TEST_PATTERN_EN
// - rgb_in       in   12   {r,g,b} from draw pipeline, valid PIPE_DELAY cycles after its hcount/vcount
// - hcount       out  CW   current pixel column, 0..H_TOTAL-1
// - vcount       out  CW   current line, 0..V_TOTAL-1
// - hblnk        out  1    1 when hcount >= H_ACTIVE
// - vblnk        out  1    1 when vcount >= V_ACTIVE
// - frame_start  out  1    one-cycle pulse when hcount==0 && vcount==0
// - hs           out  1    horizontal sync to pin, pipeline-aligned
// - vs           out  1    vertical sync to pin, pipeline-aligned
// - r, g, b      out  4    colour to pin; 0 while blanked
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - hcount=vcount=0; hblnk=vblnk=0; frame_start=0; r=g=b=0; hs=vs=~SYNC_POL.
//   - All delay-line stages load {hs,vs}=~SYNC_POL and blank=1.
//   - Release mid-frame restarts timing at (0,0). No partial line is completed.
// - Counting:
//   - hcount increments every clk and wraps H_TOTAL-1 -> 0.
//   - vcount increments only on the hcount wrap, and wraps V_TOTAL-1 -> 0 on the same edge hcount wraps.
//   - All timing outputs are registered and derived from the next-count values, so hblnk/vblnk/frame_start coincide with their hcount/vcount.
// - Raw sync:
//   - hs_raw = SYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
//   - vs_raw uses the same rule on vcount with V_*. vs changes together with hcount==0.
// - Output stage:
//   - {hs_raw, vs_raw, hblnk|vblnk} shift through PIPE_DELAY registers.
//   - Stage PIPE_DELAY drives hs/vs and gates {r,g,b} = blank_d ? 12'h000 : rgb_in, registered in that same stage.
//   - Total sync-to-pin latency is PIPE_DELAY cycles.
// - Counter width is fixed at CW. Compare arithmetic is unsigned, CW+1 bits, to avoid overflow at the porch sums.
// CONFIGURATION
// - VGA_TEST_PATTERN_EN defined: when pattern_sel != 0, rgb_in is replaced at the gating stage.
//   - pattern_sel 1: 8 vertical colour bars, index = delayed hcount[9:7].
//   - pattern_sel 2: 32x32 checker, white/black by hcount[5]^vcount[5].
//   - pattern_sel 3: solid 12'hF00.
//   - pattern_sel 0: rgb_in passes through.
//   - Delayed counters are carried through the delay line only when the macro is defined.
// - VGA_TEST_PATTERN_EN undefined: pattern_sel is unconnected and rgb_in always passes through.
// STRUCTURE
// - Package vga_pkg holds:
//   - typedef rgb_t (struct: logic [3:0] r, g, b).
//   - localparams for the 1024x768@60 timing set (H_/V_ constants, SYNC_POL).
//   - localparam function tot() returning porch sums.
// - Sub-module vga_sync_delay: parametrised shift register (WIDTH, DEPTH) carrying {hs, vs, blank[, hcount, vcount]}.
// - Counters and raw-sync decoding stay in the top of this module.
// TESTING
// 1. Hold rst=0 for 3 clk -> hcount=vcount=0, r/g/b=0, hs=vs=1; then release -> hcount=1 on first clk.
// 2. Free-run 1 line -> hs low for exactly 136 clk, starting PIPE_DELAY clk after hcount==1048.
//    Line period is 1344 clk.
// 3. Free-run 2 frames -> frame_start pulses exactly once per 1083264 clk.
//    vs low for 6 lines starting after vcount==771.
// 4. rgb_in=12'hFFF constant -> r/g/b=F only for 1024 clk per line and 768 lines per frame; 0 elsewhere.
//    Edges offset PIPE_DELAY clk from hblnk.
// 5. Assert rst=0 at hcount=500, vcount=300 for 1 clk -> next clk restart at (1,0).
//    hs/vs are inactive and rgb is 0 for PIPE_DELAY clk.
// 6. VGA_TEST_PATTERN_EN, pattern_sel=2 -> pixel (32,0) = 12'hFFF, pixel (32,32) = 12'h000.
//    pattern_sel=3 -> all active pixels 12'hF00.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, 1024x768@60 timing constants and porch-sum helper for the VGA output path.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam int   XGA_H_ACTIVE = 1024;
    localparam int   XGA_H_FP     = 24;
    localparam int   XGA_H_SYNC   = 136;
    localparam int   XGA_H_BP     = 160;
    localparam int   XGA_V_ACTIVE = 768;
    localparam int   XGA_V_FP     = 3;
    localparam int   XGA_V_SYNC   = 6;
    localparam int   XGA_V_BP     = 29;
    localparam logic XGA_SYNC_POL = 1'b0;

    function automatic int tot(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Parametrised shift register carrying sync/blank (and optionally counters) alongside the draw pipeline.
module vga_sync_delay #(
    parameter int unsigned        WIDTH   = 3,
    parameter int unsigned        DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = clk ^ rst;
            assign q = d;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
                end else begin
                    sr[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctl.sv
// VGA timing generator and pin output stage; define VGA_TEST_PATTERN_EN to enable built-in test patterns.
module vga_timing_ctl
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = XGA_H_ACTIVE,
    parameter int   H_FP       = XGA_H_FP,
    parameter int   H_SYNC     = XGA_H_SYNC,
    parameter int   H_BP       = XGA_H_BP,
    parameter int   V_ACTIVE   = XGA_V_ACTIVE,
    parameter int   V_FP       = XGA_V_FP,
    parameter int   V_SYNC     = XGA_V_SYNC,
    parameter int   V_BP       = XGA_V_BP,
    parameter logic SYNC_POL   = XGA_SYNC_POL,
    parameter int   PIPE_DELAY = 2,
    parameter int   CW         = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pattern_sel,
    input  logic [11:0]   rgb_in,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hblnk,
    output logic          vblnk,
    output logic          frame_start,
    output logic          hs,
    output logic          vs,
    output logic [3:0]    r,
    output logic [3:0]    g,
    output logic [3:0]    b
);

    localparam int          H_TOTAL  = tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int          V_TOTAL  = tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW:0] HA_C     = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] VA_C     = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_START = (CW+1)'(tot(H_ACTIVE, H_FP, 0, 0));
    localparam logic [CW:0] HS_END   = (CW+1)'(tot(H_ACTIVE, H_FP, H_SYNC, 0));
    localparam logic [CW:0] VS_START = (CW+1)'(tot(V_ACTIVE, V_FP, 0, 0));
    localparam logic [CW:0] VS_END   = (CW+1)'(tot(V_ACTIVE, V_FP, V_SYNC, 0));

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DW = 3 + 2*CW;
    localparam logic [DW-1:0] D_RST = {~SYNC_POL, ~SYNC_POL, 1'b1, {(2*CW){1'b0}}};
`else
    localparam int unsigned DW = 3;
    localparam logic [DW-1:0] D_RST = {~SYNC_POL, ~SYNC_POL, 1'b1};
`endif

    logic [CW-1:0] h_next, v_next;
    logic [CW:0]   h_ext, v_ext;
    logic          hs_raw, vs_raw;
    logic [DW-1:0] d_in, d_out;
    logic          hs_d, vs_d, blank_d;
    rgb_t          src, pix;

    always_comb begin
        h_next = (hcount == H_LAST) ? '0 : hcount + 1'b1;
        v_next = vcount;
        if (hcount == H_LAST) v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end

    // Flags are registered from the next-count values so they line up with hcount/vcount.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= ({1'b0, h_next} >= HA_C);
            vblnk       <= ({1'b0, v_next} >= VA_C);
            frame_start <= (h_next == '0) && (v_next == '0);
        end
    end

    assign h_ext  = {1'b0, hcount};
    assign v_ext  = {1'b0, vcount};
    assign hs_raw = (h_ext >= HS_START && h_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = (v_ext >= VS_START && v_ext < VS_END) ? SYNC_POL : ~SYNC_POL;

`ifdef VGA_TEST_PATTERN_EN
    logic [CW-1:0] hd, vd;
    logic          unused_cnt;
    assign d_in = {hs_raw, vs_raw, hblnk | vblnk, hcount, vcount};
    assign {hs_d, vs_d, blank_d, hd, vd} = d_out;
    assign unused_cnt = ^{hd, vd};

    always_comb begin
        src = rgb_t'(rgb_in);
        case (pattern_sel)
            2'd1:    src = rgb_t'({{4{hd[9]}}, {4{hd[8]}}, {4{hd[7]}}});
            2'd2:    src = rgb_t'((hd[5] ^ vd[5]) ? 12'hFFF : 12'h000);
            2'd3:    src = rgb_t'(12'hF00);
            default: src = rgb_t'(rgb_in);
        endcase
    end
`else
    logic unused_sel;
    assign d_in = {hs_raw, vs_raw, hblnk | vblnk};
    assign {hs_d, vs_d, blank_d} = d_out;
    assign unused_sel = ^pattern_sel;
    assign src = rgb_t'(rgb_in);
`endif

    // The delay line holds PIPE_DELAY-1 stages; the output register below is the final one.
    vga_sync_delay #(
        .WIDTH   (DW),
        .DEPTH   (PIPE_DELAY - 1),
        .RST_VAL (D_RST)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (d_in),
        .q   (d_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            hs  <= ~SYNC_POL;
            vs  <= ~SYNC_POL;
            pix <= '0;
        end else begin
            hs  <= hs_d;
            vs  <= vs_d;
            pix <= blank_d ? rgb_t'(12'h000) : src;
        end
    end

    assign r = pix.r;
    assign g = pix.g;
    assign b = pix.b;

endmodule

// File: tb/tb_vga_timing_ctl.sv
// Randomised self-checking bench for vga_timing_ctl on a reduced timing set; pattern checks need VGA_TEST_PATTERN_EN.
module tb_vga_timing_ctl;

    localparam int   HA = 48, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
    localparam int   VA = 40, VF = 2, VS = 3, VB = 3, VT = VA + VF + VS + VB;
    localparam int   FRAME = HT * VT;
    localparam int   PD = 3;
    localparam int   CW = 11;
    localparam logic POL = 1'b0;

    logic          clk, rst;
    logic [1:0]    pattern_sel;
    logic [11:0]   rgb_in;
    logic [CW-1:0] hcount, vcount;
    logic          hblnk, vblnk, frame_start, hs, vs;
    logic [3:0]    r, g, b;

    int          n;
    logic [11:0] rgb_edge;
    logic [1:0]  sel_edge;
    int          checks;
    int          fails;

    vga_timing_ctl #(
        .H_ACTIVE   (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE   (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL   (POL),
        .PIPE_DELAY (PD),
        .CW         (CW)
    ) dut (
        .clk (clk), .rst (rst), .pattern_sel (pattern_sel), .rgb_in (rgb_in),
        .hcount (hcount), .vcount (vcount), .hblnk (hblnk), .vblnk (vblnk),
        .frame_start (frame_start), .hs (hs), .vs (vs), .r (r), .g (g), .b (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {hcount, vcount, hblnk, vblnk, frame_start} k edges after the last reset edge.
    function automatic logic [2*CW+2:0] exp_timing(input int k);
        int h, v;
        h = k % HT;
        v = (k / HT) % VT;
        return {CW'(h), CW'(v), h >= HA, v >= VA, (k > 0 && h == 0 && v == 0)};
    endfunction

    function automatic logic [11:0] pixel_colour(input int h, input int v, input logic [11:0] rgb,
                                                 input logic [1:0] sel);
        logic [11:0] col;
        int          i;
        col = rgb;
`ifdef VGA_TEST_PATTERN_EN
        i = (h / 128) % 8;
        case (sel)
            2'd1: col = {(i / 4) % 2 == 1 ? 4'hF : 4'h0, (i / 2) % 2 == 1 ? 4'hF : 4'h0,
                         i % 2 == 1 ? 4'hF : 4'h0};
            2'd2: col = ((h / 32 + v / 32) % 2 == 1) ? 12'hFFF : 12'h000;
            2'd3: col = 12'hF00;
            default: col = rgb;
        endcase
`else
        i = h + v + int'(sel);
`endif
        return col;
    endfunction

    // Expected {hs, vs, r, g, b}: pins show pixel k-PD, or the idle state just after reset.
    function automatic logic [13:0] exp_pins(input int k, input logic [11:0] rgb, input logic [1:0] sel);
        int   p, h, v;
        logic hsv, vsv;
        if (k < PD) return {~POL, ~POL, 12'h000};
        p   = k - PD;
        h   = p % HT;
        v   = (p / HT) % VT;
        hsv = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
        vsv = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
        if (h >= HA || v >= VA) return {hsv, vsv, 12'h000};
        return {hsv, vsv, pixel_colour(h, v, rgb, sel)};
    endfunction

    task automatic tick(input logic [11:0] next_rgb, input logic [1:0] next_sel, input logic next_rst);
        rgb_in      = next_rgb;
        pattern_sel = next_sel;
        rst         = next_rst;
        @(posedge clk);
        rgb_edge = rgb_in;
        sel_edge = pattern_sel;
        if (!rst) n = 0;
        else      n = n + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(12'($urandom), 2'($urandom), 1'b0);
            checks++;
            if ({hcount, vcount, hblnk, vblnk, frame_start} !== exp_timing(n)) begin
                fails++;
                $display("FAIL reset_timing n=%0d got %h want %h", n,
                         {hcount, vcount, hblnk, vblnk, frame_start}, exp_timing(n));
            end
            checks++;
            if ({hs, vs, r, g, b} !== {~POL, ~POL, 12'h000}) begin
                fails++;
                $display("FAIL reset_pins got %h want %h", {hs, vs, r, g, b}, {~POL, ~POL, 12'h000});
            end
        end
        tick(12'($urandom), 2'd0, 1'b1);
        checks++;
        if ({hcount, vcount} !== {CW'(1), CW'(0)}) begin
            fails++;
            $display("FAIL release_count got h=%0d v=%0d want h=1 v=0", hcount, vcount);
        end
    endtask

    task automatic test_line();
        logic prev_hs;
        int   fall_n, last_fall, pulses;
        prev_hs   = hs;
        fall_n    = -1;
        last_fall = -1;
        pulses    = 0;
        for (int i = 0; i < 3 * HT; i++) begin
            tick(12'($urandom), 2'd0, 1'b1);
            checks++;
            if ({hcount, vcount, hblnk, vblnk, frame_start} !== exp_timing(n)) begin
                fails++;
                $display("FAIL line_timing n=%0d got %h want %h", n,
                         {hcount, vcount, hblnk, vblnk, frame_start}, exp_timing(n));
            end
            checks++;
            if ({hs, vs, r, g, b} !== exp_pins(n, rgb_edge, sel_edge)) begin
                fails++;
                $display("FAIL line_pins n=%0d got %h want %h", n, {hs, vs, r, g, b},
                         exp_pins(n, rgb_edge, sel_edge));
            end
            if (prev_hs !== POL && hs === POL) begin
                if (last_fall >= 0) begin
                    checks++;
                    if (n - last_fall != HT) begin
                        fails++;
                        $display("FAIL line_period got %0d want %0d", n - last_fall, HT);
                    end
                end
                last_fall = n;
                fall_n    = n;
            end
            if (prev_hs === POL && hs !== POL && fall_n >= 0) begin
                pulses++;
                checks++;
                if (n - fall_n != HS) begin
                    fails++;
                    $display("FAIL hs_width got %0d want %0d", n - fall_n, HS);
                end
            end
            prev_hs = hs;
        end
        checks++;
        if (pulses < 2) begin
            fails++;
            $display("FAIL hs_pulses got %0d want at least 2", pulses);
        end
    endtask

    task automatic test_frames();
        int fs_count, vs_cycles, last_fs;
        fs_count  = 0;
        vs_cycles = 0;
        last_fs   = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(12'($urandom), 2'($urandom), 1'b1);
            checks++;
            if ({hcount, vcount, hblnk, vblnk, frame_start} !== exp_timing(n)) begin
                fails++;
                $display("FAIL frame_timing n=%0d got %h want %h", n,
                         {hcount, vcount, hblnk, vblnk, frame_start}, exp_timing(n));
            end
            checks++;
            if ({hs, vs, r, g, b} !== exp_pins(n, rgb_edge, sel_edge)) begin
                fails++;
                $display("FAIL frame_pins n=%0d got %h want %h", n, {hs, vs, r, g, b},
                         exp_pins(n, rgb_edge, sel_edge));
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (n - last_fs != FRAME) begin
                        fails++;
                        $display("FAIL frame_period got %0d want %0d", n - last_fs, FRAME);
                    end
                end
                last_fs = n;
                fs_count++;
            end
            if (vs === POL) vs_cycles++;
        end
        checks++;
        if (fs_count != 2) begin
            fails++;
            $display("FAIL frame_start_count got %0d want 2", fs_count);
        end
        checks++;
        if (vs_cycles != 2 * VS * HT) begin
            fails++;
            $display("FAIL vs_cycles got %0d want %0d", vs_cycles, 2 * VS * HT);
        end
    endtask

    task automatic test_blank_rgb();
        int lit;
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(12'hFFF, 2'd0, 1'b1);
            checks++;
            if ({hs, vs, r, g, b} !== exp_pins(n, rgb_edge, sel_edge)) begin
                fails++;
                $display("FAIL blank_pins n=%0d got %h want %h", n, {hs, vs, r, g, b},
                         exp_pins(n, rgb_edge, sel_edge));
            end
            if ({r, g, b} === 12'hFFF) lit++;
        end
        checks++;
        if (lit != HA * VA) begin
            fails++;
            $display("FAIL lit_pixels got %0d want %0d", lit, HA * VA);
        end
    endtask

    task automatic test_mid_reset();
        int   th, tv;
        logic hit;
        th  = $urandom_range(HT - 1, 1);
        tv  = $urandom_range(VT - 1, 1);
        hit = 1'b0;
        for (int i = 0; i < FRAME + 2 && !hit; i++) begin
            if (n % HT == th && (n / HT) % VT == tv) hit = 1'b1;
            else tick(12'($urandom), 2'd0, 1'b1);
        end
        checks++;
        if (!hit || {hcount, vcount} !== {CW'(th), CW'(tv)}) begin
            fails++;
            $display("FAIL reach_target got h=%0d v=%0d want h=%0d v=%0d", hcount, vcount, th, tv);
        end
        tick(12'($urandom), 2'd0, 1'b0);
        checks++;
        if ({hcount, vcount, frame_start} !== {CW'(0), CW'(0), 1'b0}) begin
            fails++;
            $display("FAIL mid_reset_count got h=%0d v=%0d fs=%b want 0 0 0", hcount, vcount, frame_start);
        end
        for (int i = 0; i < HT + PD; i++) begin
            if (n < PD) begin
                checks++;
                if ({hs, vs, r, g, b} !== {~POL, ~POL, 12'h000}) begin
                    fails++;
                    $display("FAIL restart_idle n=%0d got %h want %h", n, {hs, vs, r, g, b},
                             {~POL, ~POL, 12'h000});
                end
            end
            tick(12'($urandom), 2'd0, 1'b1);
            if (n == 1) begin
                checks++;
                if ({hcount, vcount} !== {CW'(1), CW'(0)}) begin
                    fails++;
                    $display("FAIL restart_count got h=%0d v=%0d want h=1 v=0", hcount, vcount);
                end
            end
            checks++;
            if ({hcount, vcount, hblnk, vblnk, frame_start} !== exp_timing(n)) begin
                fails++;
                $display("FAIL restart_timing n=%0d got %h want %h", n,
                         {hcount, vcount, hblnk, vblnk, frame_start}, exp_timing(n));
            end
            checks++;
            if ({hs, vs, r, g, b} !== exp_pins(n, rgb_edge, sel_edge)) begin
                fails++;
                $display("FAIL restart_pins n=%0d got %h want %h", n, {hs, vs, r, g, b},
                         exp_pins(n, rgb_edge, sel_edge));
            end
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int p;
        for (int s = 2; s <= 3; s++) begin
            for (int i = 0; i < FRAME; i++) begin
                tick(12'($urandom), 2'(s), 1'b1);
                p = n - PD;
                checks++;
                if ({hs, vs, r, g, b} !== exp_pins(n, rgb_edge, sel_edge)) begin
                    fails++;
                    $display("FAIL pattern%0d_pins n=%0d got %h want %h", s, n, {hs, vs, r, g, b},
                             exp_pins(n, rgb_edge, sel_edge));
                end
                if (s == 2 && p >= 0 && p % HT == 32 && (p / HT) % VT == 0) begin
                    checks++;
                    if ({r, g, b} !== 12'hFFF) begin
                        fails++;
                        $display("FAIL checker_32_0 got %h want fff", {r, g, b});
                    end
                end
                if (s == 2 && p >= 0 && p % HT == 32 && (p / HT) % VT == 32) begin
                    checks++;
                    if ({r, g, b} !== 12'h000) begin
                        fails++;
                        $display("FAIL checker_32_32 got %h want 000", {r, g, b});
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        checks      = 0;
        fails       = 0;
        n           = 0;
        rst         = 1'b0;
        rgb_in      = '0;
        pattern_sel = '0;
        rgb_edge    = '0;
        sel_edge    = '0;
        test_reset();
        test_line();
        test_frames();
        test_blank_rgb();
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
